seq_binary_to_bcd: RTL and testbench



---
 rtl/seq_binary_to_bcd.sv | 103 ++++++++++
 tb/tb_seq_binary_to_bcd.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_binary_to_bcd.sv
// Iterative shift-and-add-3 binary to packed BCD converter.
// One bit per clock, start/done handshake, registered outputs.
module seq_binary_to_bcd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [BW-1:0]   adj;
  logic            stk_q, stk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_d;
  logic            ovf_d;
  logic            done_d;

  assign busy = (state_q == SHIFT);

  // Add 3 to every scratch digit >= 5 before it is shifted.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state, datapath and result update.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd;
    ovf_d   = ovf;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          stk_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        stk_d = stk_q | adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_d;
          ovf_d   = stk_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      stk_q   <= 1'b0;
      cnt_q   <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      bcd     <= bcd_d;
      ovf     <= ovf_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Scoreboard bench for seq_binary_to_bcd.
// Second instance with DIGITS=4 covers overflow.
module tb_seq_binary_to_bcd;

  localparam int W = 14;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [W-1:0] bin;
  logic        busy, done, ovf;
  logic [19:0] bcd;

  logic        start4;
  logic [W-1:0] bin4;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  bit prev_done = 1'b0;

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  seq_binary_to_bcd #(.WIDTH(W), .DIGITS(5)) u_dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ovf     (ovf)
  );

  seq_binary_to_bcd #(.WIDTH(W), .DIGITS(4)) u_dut4 (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .start   (start4),
    .bin     (bin4),
    .busy    (busy4),
    .done    (done4),
    .bcd     (bcd4),
    .ovf     (ovf4)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Pop and compare on every done pulse.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (RESET_N) begin
      if (done) begin
        n_done++;
        chk("done_width", {31'b0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bcd", {12'b0, bcd}, {12'b0, e.bcd});
          chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
          chk("latency", cyc, e.due);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic conv(input int v, input bit hold);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (busy) begin
      chk("busy_timeout", {31'b0, busy}, 32'd0);
      return;
    end
    bin = W'(v);
    start = 1'b1;
    sb.push_back('{ref_bcd(v), (v >= 100000), cyc + 1 + W});
    @(negedge CLOCK_50);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic conv4(input int v,
                       input logic [15:0] eb,
                       input logic eo);
    int t;
    bin4 = W'(v);
    start4 = 1'b1;
    @(negedge CLOCK_50);
    start4 = 1'b0;
    t = 0;
    while (!done4 && t < 40) begin
      @(negedge CLOCK_50);
      t++;
    end
    chk("d4_done", {31'b0, done4}, 32'd1);
    chk("d4_bcd", {16'b0, bcd4}, {16'b0, eb});
    chk("d4_ovf", {31'b0, ovf4}, {31'b0, eo});
  endtask

  initial begin
    int d0;
    RESET_N = 1'b0;
    start = 1'b0;
    bin = '0;
    start4 = 1'b0;
    bin4 = '0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_bcd", {12'b0, bcd}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    conv4(16383, 16'h6383, 1'b1);
    conv4(9999, 16'h9999, 1'b0);

    conv(500, 1'b0);
    drain();
    d0 = n_done;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      bin = W'($urandom);
      if (i % 10 == 9)
        chk("hold_bcd", {12'b0, bcd}, 32'h500);
    end
    chk("hold_done", n_done - d0, 32'd0);

    conv(1234, 1'b0);
    repeat (4) @(negedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_bcd", {12'b0, bcd}, 32'd0);
    chk("mid_ovf", {31'b0, ovf}, 32'd0);
    sb.delete();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    conv(37, 1'b0);
    drain();

    conv(0, 1'b0);
    conv(9999, 1'b0);
    conv(16383, 1'b0);
    drain();

    conv(1234, 1'b0);
    repeat (2) @(negedge CLOCK_50);
    bin = W'(42);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (9) @(negedge CLOCK_50);
    bin = W'(42);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    drain();
    repeat (20) @(negedge CLOCK_50);
    chk("busy_idle", {31'b0, busy}, 32'd0);

    for (int v = 0; v < 3000; v++) conv(v, 1'b1);
    for (int v = 16383; v > 15800; v--) conv(v, 1'b1);
    for (int i = 0; i < 600; i++)
      conv(int'($urandom_range(0, 16383)), 1'b1);
    @(negedge CLOCK_50);
    start = 1'b0;
    drain();
    repeat (20) @(negedge CLOCK_50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
